// File: rtl/same_label_reg_Consts.sv
// Register-map constants for the same_label_reg block: window size, word
// addresses, field geometry, field masks and the NO_FIELDS preset value.
package same_label_reg_Consts;

    // Size of the register window in bytes
    localparam int unsigned SAME_LABEL_REG_SIZE = 16;

    // Word-aligned byte addresses
    localparam logic [31:0] ADDR_NO_FIELDS       = 32'h0000_0000;
    localparam logic [31:0] ADDR_SAME_NAME       = 32'h0000_0004;
    localparam logic [31:0] ADDR_SAME_NAME_MULTI = 32'h0000_0008;
    localparam logic [31:0] ADDR_NOT_SAME        = 32'h0000_000C;

    // NO_FIELDS: read-only constant word
    localparam int unsigned NO_FIELDS_WIDTH  = 8;
    localparam logic [NO_FIELDS_WIDTH-1:0] NO_FIELDS_PRESET = 8'h20;

    // SAME_NAME: single bit
    localparam int unsigned SAME_NAME_WIDTH  = 1;
    localparam int unsigned SAME_NAME_OFFSET = 0;
    localparam logic [31:0] SAME_NAME_MASK   = 32'h0000_0001;

    // SAME_NAME_MULTI: twelve bits
    localparam int unsigned SAME_NAME_MULTI_WIDTH  = 12;
    localparam int unsigned SAME_NAME_MULTI_OFFSET = 0;
    localparam logic [31:0] SAME_NAME_MULTI_MASK   = 32'h0000_0FFF;

    // NOT_SAME: single bit
    localparam int unsigned NOT_SAME_WIDTH  = 1;
    localparam int unsigned NOT_SAME_OFFSET = 0;
    localparam logic [31:0] NOT_SAME_MASK   = 32'h0000_0001;

endpackage

// File: rtl/same_label_reg_wb_pkg.sv
// Types and helpers local to the Wishbone front end of same_label_reg.
package same_label_reg_wb_pkg;

    // Bus handshake state: waiting for a strobe, or presenting ack/err
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } wb_state_e;

    // Clears the byte-offset bits so a byte address becomes a word address
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Replace the bits of old_w that are both enabled by a byte lane and
    // belong to the field, keeping every other bit.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [31:0] lanes,
        input logic [31:0] field_mask
    );
        logic [31:0] upd;
        upd = lanes & field_mask;
        return (old_w & ~upd) | (new_w & upd);
    endfunction

endpackage

// File: rtl/same_label_reg_wb.sv
// Wishbone B4 classic slave for the same_label_reg map: two-state handshake
// with one-cycle response, byte-lane writes and per-register write pulses.
module same_label_reg_wb
    import same_label_reg_Consts::*;
    import same_label_reg_wb_pkg::*;
#(
    parameter int G_ADDR_W    = 5,
    parameter bit G_STROBE_EN = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [G_ADDR_W-1:0]              wb_adr_i,
    input  logic [3:0]                       wb_sel_i,
    input  logic [31:0]                      wb_dat_i,
    output logic [31:0]                      wb_dat_o,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             wb_stall_o,
    output logic [SAME_NAME_WIDTH-1:0]       same_name_o,
    output logic [SAME_NAME_MULTI_WIDTH-1:0] same_name_multi_o,
    output logic [NOT_SAME_WIDTH-1:0]        not_same_o,
    output logic                             same_name_multi_wr_o,
    output logic                             not_same_wr_o
);

    wb_state_e                        state_q, state_d;
    logic                             err_q, err_d;
    logic [31:0]                      dat_q, dat_d;
    logic [SAME_NAME_WIDTH-1:0]       same_name_q, same_name_d;
    logic [SAME_NAME_MULTI_WIDTH-1:0] same_name_multi_q, same_name_multi_d;
    logic [NOT_SAME_WIDTH-1:0]        not_same_q, not_same_d;
    logic                             multi_wr_q, multi_wr_d;
    logic                             not_same_wr_q, not_same_wr_d;

    logic [31:0] adr_word;
    logic [31:0] reg_adr;
    logic        err_cond;
    logic        hit_no_fields;
    logic        hit_same_name;
    logic        hit_multi;
    logic        hit_not_same;
    logic [31:0] lane_mask;
    logic [31:0] rd_data;
    logic [31:0] same_name_word;
    logic [31:0] multi_word;
    logic [31:0] not_same_word;

    // Address decode; anything at or beyond the window end is an error
    assign adr_word      = 32'(wb_adr_i);
    assign reg_adr       = adr_word & WORD_ALIGN_MASK;
    assign err_cond      = (adr_word >= SAME_LABEL_REG_SIZE);
    assign hit_no_fields = !err_cond && (reg_adr == ADDR_NO_FIELDS);
    assign hit_same_name = !err_cond && (reg_adr == ADDR_SAME_NAME);
    assign hit_multi     = !err_cond && (reg_adr == ADDR_SAME_NAME_MULTI);
    assign hit_not_same  = !err_cond && (reg_adr == ADDR_NOT_SAME);

    // Expand byte-lane selects into a bit mask
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
        end
    endgenerate

    // Fields placed at their bus positions, for both readback and merging
    assign same_name_word = 32'(same_name_q) << SAME_NAME_OFFSET;
    assign multi_word     = 32'(same_name_multi_q) << SAME_NAME_MULTI_OFFSET;
    assign not_same_word  = 32'(not_same_q) << NOT_SAME_OFFSET;

    // Read mux; unmapped and error addresses read as zero
    always_comb begin
        rd_data = '0;
        if (hit_no_fields) rd_data = 32'(NO_FIELDS_PRESET);
        if (hit_same_name) rd_data = same_name_word;
        if (hit_multi)     rd_data = multi_word;
        if (hit_not_same)  rd_data = not_same_word;
    end

    // Next-state logic: accept in IDLE (commit writes, capture read data), then one RESP cycle
    always_comb begin
        state_d           = state_q;
        err_d             = err_q;
        dat_d             = dat_q;
        same_name_d       = same_name_q;
        same_name_multi_d = same_name_multi_q;
        not_same_d        = not_same_q;
        multi_wr_d        = 1'b0;
        not_same_wr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = RESP;
                    err_d   = err_cond;
                    dat_d   = wb_we_i ? '0 : rd_data;
                    if (wb_we_i && !err_cond) begin
                        if (hit_same_name) begin
                            same_name_d = SAME_NAME_WIDTH'(lane_merge(same_name_word, wb_dat_i,
                                lane_mask, SAME_NAME_MASK) >> SAME_NAME_OFFSET);
                        end
                        if (hit_multi) begin
                            same_name_multi_d = SAME_NAME_MULTI_WIDTH'(lane_merge(multi_word,
                                wb_dat_i, lane_mask, SAME_NAME_MULTI_MASK) >> SAME_NAME_MULTI_OFFSET);
                            multi_wr_d = G_STROBE_EN;
                        end
                        if (hit_not_same) begin
                            not_same_d = NOT_SAME_WIDTH'(lane_merge(not_same_word, wb_dat_i,
                                lane_mask, NOT_SAME_MASK) >> NOT_SAME_OFFSET);
                            not_same_wr_d = G_STROBE_EN;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, register file and strobe flops; reset clears everything at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            err_q             <= 1'b0;
            dat_q             <= '0;
            same_name_q       <= '0;
            same_name_multi_q <= '0;
            not_same_q        <= '0;
            multi_wr_q        <= 1'b0;
            not_same_wr_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            err_q             <= err_d;
            dat_q             <= dat_d;
            same_name_q       <= same_name_d;
            same_name_multi_q <= same_name_multi_d;
            not_same_q        <= not_same_d;
            multi_wr_q        <= multi_wr_d;
            not_same_wr_q     <= not_same_wr_d;
        end
    end

    // Response qualified by cyc_i so an abandoned cycle gets neither ack nor err
    assign wb_ack_o   = (state_q == RESP) && wb_cyc_i && !err_q;
    assign wb_err_o   = (state_q == RESP) && wb_cyc_i && err_q;
    assign wb_stall_o = (state_q == RESP);
    assign wb_dat_o   = dat_q;

    assign same_name_o          = same_name_q;
    assign same_name_multi_o    = same_name_multi_q;
    assign not_same_o           = not_same_q;
    assign same_name_multi_wr_o = multi_wr_q;
    assign not_same_wr_o        = not_same_wr_q;

endmodule

// File: tb/tb_same_label_reg_wb.sv
// Directed bench for same_label_reg_wb: each task drives one scenario and
// checks the bus and field outputs against hand-computed values.
module tb_same_label_reg_wb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;
    logic        same_name_o;
    logic [11:0] same_name_multi_o;
    logic        not_same_o;
    logic        same_name_multi_wr_o;
    logic        not_same_wr_o;

    int n_cmp = 0;
    int n_bad = 0;

    same_label_reg_wb #(
        .G_ADDR_W    (5),
        .G_STROBE_EN (1'b1)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .wb_cyc_i             (wb_cyc_i),
        .wb_stb_i             (wb_stb_i),
        .wb_we_i              (wb_we_i),
        .wb_adr_i             (wb_adr_i),
        .wb_sel_i             (wb_sel_i),
        .wb_dat_i             (wb_dat_i),
        .wb_dat_o             (wb_dat_o),
        .wb_ack_o             (wb_ack_o),
        .wb_err_o             (wb_err_o),
        .wb_stall_o           (wb_stall_o),
        .same_name_o          (same_name_o),
        .same_name_multi_o    (same_name_multi_o),
        .not_same_o           (not_same_o),
        .same_name_multi_wr_o (same_name_multi_wr_o),
        .not_same_wr_o        (not_same_wr_o)
    );

    always #5 clk_i = ~clk_i;

    // Present a transfer in the current IDLE cycle; returns 1 ns into the RESP cycle
    task automatic bus_start(input logic we, input logic [4:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = dat;
        @(posedge clk_i);
        #1;
    endtask

    // Release the bus and move on to the next cycle
    task automatic bus_end();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_bus got ack=%b err=%b stall=%b dat=%h want all 0",
                     wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o);
        end
        n_cmp++;
        if ({same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_fields got sn=%b snm=%h ns=%b wr=%b%b want all 0",
                     same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        $display("reset released");
    endtask

    task automatic test_read_reset_values();
        logic [31:0] exp_tbl [4];
        exp_tbl = '{32'h0000_0020, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            bus_start(1'b0, 5'(i * 4), 4'hF, 32'h0);
            n_cmp++;
            if ({wb_ack_o, wb_err_o, wb_stall_o} !== 3'b101) begin
                n_bad++;
                $display("FAIL rd_reset_hs adr=%h got ack/err/stall=%b%b%b want 101",
                         i * 4, wb_ack_o, wb_err_o, wb_stall_o);
            end
            n_cmp++;
            if (wb_dat_o !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL rd_reset_dat adr=%h got %h want %h", i * 4, wb_dat_o, exp_tbl[i]);
            end
            $display("read adr=%h dat=%h", i * 4, wb_dat_o);
            bus_end();
        end
    endtask

    task automatic test_multi_lanes();
        bus_start(1'b1, 5'h08, 4'b0001, 32'hFFFF_FFFF);
        n_cmp++;
        if (same_name_multi_o !== 12'h0FF || same_name_multi_wr_o !== 1'b1 || wb_ack_o !== 1'b1) begin
            n_bad++;
            $display("FAIL multi_lane0 got field=%h wr=%b ack=%b want 0ff 1 1",
                     same_name_multi_o, same_name_multi_wr_o, wb_ack_o);
        end
        n_cmp++;
        if (wb_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL write_clears_dat got %h want 00000000", wb_dat_o);
        end
        $display("write adr=08 sel=1 field=%h", same_name_multi_o);
        bus_end();
        n_cmp++;
        if (same_name_multi_wr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL multi_wr_one_cycle got %b want 0", same_name_multi_wr_o);
        end
        bus_start(1'b1, 5'h08, 4'b0010, 32'hFFFF_FFFF);
        n_cmp++;
        if (same_name_multi_o !== 12'hFFF || same_name_multi_wr_o !== 1'b1) begin
            n_bad++;
            $display("FAIL multi_lane1 got field=%h wr=%b want fff 1", same_name_multi_o, same_name_multi_wr_o);
        end
        $display("write adr=08 sel=2 field=%h", same_name_multi_o);
        bus_end();
        bus_start(1'b0, 5'h08, 4'hF, 32'h0);
        n_cmp++;
        if (wb_dat_o !== 32'h0000_0FFF) begin
            n_bad++;
            $display("FAIL multi_readback got %h want 00000fff", wb_dat_o);
        end
        $display("read adr=08 dat=%h", wb_dat_o);
        bus_end();
    endtask

    task automatic test_single_bits();
        bus_start(1'b1, 5'h04, 4'hF, 32'h1);
        n_cmp++;
        if (same_name_o !== 1'b1 || not_same_wr_o !== 1'b0 || same_name_multi_wr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL same_name_wr got sn=%b nswr=%b snmwr=%b want 1 0 0",
                     same_name_o, not_same_wr_o, same_name_multi_wr_o);
        end
        $display("write adr=04 sn=%b", same_name_o);
        bus_end();
        bus_start(1'b1, 5'h0C, 4'hF, 32'h3);
        n_cmp++;
        if (not_same_o !== 1'b1 || not_same_wr_o !== 1'b1) begin
            n_bad++;
            $display("FAIL not_same_wr got ns=%b wr=%b want 1 1", not_same_o, not_same_wr_o);
        end
        $display("write adr=0c ns=%b", not_same_o);
        bus_end();
        n_cmp++;
        if (not_same_wr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL not_same_wr_one_cycle got %b want 0", not_same_wr_o);
        end
        // lane 0 disabled: bit must hold
        bus_start(1'b1, 5'h04, 4'b1110, 32'h0);
        n_cmp++;
        if (same_name_o !== 1'b1) begin
            n_bad++;
            $display("FAIL same_name_sel_gate got %b want 1", same_name_o);
        end
        $display("write adr=04 sel=e sn=%b", same_name_o);
        bus_end();
        bus_start(1'b1, 5'h00, 4'hF, 32'h0);
        n_cmp++;
        if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ro_write_ack got ack=%b err=%b want 1 0", wb_ack_o, wb_err_o);
        end
        $display("write adr=00 ack=%b", wb_ack_o);
        bus_end();
        bus_start(1'b0, 5'h00, 4'hF, 32'h0);
        n_cmp++;
        if (wb_dat_o !== 32'h0000_0020) begin
            n_bad++;
            $display("FAIL ro_readback got %h want 00000020", wb_dat_o);
        end
        $display("read adr=00 dat=%h", wb_dat_o);
        bus_end();
    endtask

    task automatic test_errors();
        bus_start(1'b0, 5'h10, 4'hF, 32'h0);
        n_cmp++;
        if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL err_read got err=%b ack=%b dat=%h want 1 0 00000000", wb_err_o, wb_ack_o, wb_dat_o);
        end
        $display("read adr=10 err=%b", wb_err_o);
        bus_end();
        bus_start(1'b1, 5'h1C, 4'hF, 32'hFFFF_FFFF);
        n_cmp++;
        if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_write got err=%b ack=%b want 1 0", wb_err_o, wb_ack_o);
        end
        n_cmp++;
        if ({same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o}
                !== {1'b1, 12'hFFF, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL err_write_no_effect got sn=%b snm=%h ns=%b wr=%b%b want 1 fff 1 00",
                     same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o);
        end
        $display("write adr=1c err=%b", wb_err_o);
        bus_end();
    endtask

    task automatic test_back_to_back();
        bus_start(1'b0, 5'h08, 4'hF, 32'h0);
        n_cmp++;
        if (wb_stall_o !== 1'b1 || wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0000_0FFF) begin
            n_bad++;
            $display("FAIL b2b_first got stall=%b ack=%b dat=%h want 1 1 00000fff", wb_stall_o, wb_ack_o, wb_dat_o);
        end
        $display("b2b first adr=08 dat=%h", wb_dat_o);
        wb_adr_i = 5'h04;      // second strobe held against stall
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (wb_stall_o !== 1'b0 || wb_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap got stall=%b ack=%b want 0 0", wb_stall_o, wb_ack_o);
        end
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL b2b_second got ack=%b dat=%h want 1 00000001", wb_ack_o, wb_dat_o);
        end
        $display("b2b second adr=04 dat=%h", wb_dat_o);
        bus_end();
    endtask

    task automatic test_cyc_drop();
        bus_start(1'b1, 5'h08, 4'b0011, 32'h0000_0ABC);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        #1;
        n_cmp++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL cyc_drop_noack got ack=%b err=%b want 0 0", wb_ack_o, wb_err_o);
        end
        n_cmp++;
        if (same_name_multi_o !== 12'hABC || same_name_multi_wr_o !== 1'b1) begin
            n_bad++;
            $display("FAIL cyc_drop_commit got field=%h wr=%b want abc 1", same_name_multi_o, same_name_multi_wr_o);
        end
        $display("write adr=08 cyc dropped field=%h", same_name_multi_o);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_async_reset();
        bus_start(1'b0, 5'h00, 4'hF, 32'h0);
        n_cmp++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0000_0020) begin
            n_bad++;
            $display("FAIL rst_pre got ack=%b dat=%h want 1 00000020", wb_ack_o, wb_dat_o);
        end
        #1;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o} !== 35'd0) begin
            n_bad++;
            $display("FAIL rst_async_bus got ack=%b err=%b stall=%b dat=%h want all 0",
                     wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o);
        end
        n_cmp++;
        if ({same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o} !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_async_fields got sn=%b snm=%h ns=%b wr=%b%b want all 0",
                     same_name_o, same_name_multi_o, not_same_o, same_name_multi_wr_o, not_same_wr_o);
        end
        $display("async reset mid-RESP");
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus_start(1'b0, 5'h08, 4'hF, 32'h0);
        n_cmp++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_then_read got ack=%b dat=%h want 1 00000000", wb_ack_o, wb_dat_o);
        end
        $display("read after reset adr=08 dat=%h", wb_dat_o);
        bus_end();
    endtask

    initial begin
        test_reset();
        test_read_reset_values();
        test_multi_lanes();
        test_single_bits();
        test_errors();
        test_back_to_back();
        test_cyc_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
